// File: rtl/csr_mmio_initiator_pkg.sv
// csr_mmio_initiator_pkg: shared types, MMIO request/response layouts and constants for the CSR MMIO initiator
package csr_mmio_initiator_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RSP} t_csr_init_state;
  typedef logic [14:0] t_csr_init_idx;
  typedef logic [8:0] t_csr_init_tid;
  localparam logic [1:0] CSR_INIT_LEN_64 = 2'b01;
  typedef struct packed {
    logic [15:0] address;
    logic [1:0] length;
    logic rsvd;
    t_csr_init_tid tid;
  } t_ccip_c0_ReqMmioHdr;
  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0] data;
    logic rspValid;
    logic mmioRdValid;
    logic mmioWrValid;
  } t_if_cci_c0_Rx;
  typedef struct packed {
    t_csr_init_tid tid;
  } t_ccip_c2_RspMmioHdr;
  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic mmioRdValid;
    logic [63:0] data;
  } t_if_cci_c2_Tx;
  function automatic logic [15:0] csr_init_addr(input t_csr_init_idx idx);
    return {idx, 1'b0};
  endfunction
endpackage

// File: rtl/csr_mmio_initiator_watchdog.sv
// csr_init_watchdog: read-response watchdog, only built when CSR_MMIO_INITIATOR_TIMEOUT_EN is defined
`ifdef CSR_MMIO_INITIATOR_TIMEOUT_EN
module csr_init_watchdog
  import csr_mmio_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] r_count;
  assign expired = run && r_count == CW'(TIMEOUT_CYCLES - 1);
  // Count consecutive run cycles, restarting whenever the waiter leaves its wait
  always_ff @(posedge clk) begin
    if (reset || clear) r_count <= '0;
    else if (run && !expired) r_count <= r_count + CW'(1);
  end
endmodule
`endif

// File: rtl/csr_mmio_initiator.sv
// csr_mmio_initiator: turns CSR commands into single MMIO requests and returns read data; watchdog via CSR_MMIO_INITIATOR_TIMEOUT_EN
module csr_mmio_initiator
  import csr_mmio_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TID_WIDTH = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_is_wr,
  input  t_csr_init_idx cmd_idx,
  input  logic [63:0] cmd_wdata,
  output t_if_cci_c0_Rx c0Rx,
  input  t_if_cci_c2_Tx c2Tx,
  output logic rsp_valid,
  output logic [63:0] rsp_data,
  output logic rsp_timeout,
  output logic busy
);
  t_csr_init_state r_state, w_next;
  logic r_is_wr;
  t_csr_init_idx r_idx;
  logic [63:0] r_wdata;
  logic [TID_WIDTH-1:0] r_tid, r_out_tid;
  logic r_rsp_valid;
  logic [63:0] r_rsp_data;
  logic w_match, w_expired;

  if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 4");
  end

  assign w_match = r_state == ST_WAIT_RSP && c2Tx.mmioRdValid && c2Tx.hdr.tid == t_csr_init_tid'(r_out_tid);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data = r_rsp_data;

`ifdef CSR_MMIO_INITIATOR_TIMEOUT_EN
  logic r_rsp_timeout;
  csr_init_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .reset(reset),
    .clear(r_state != ST_WAIT_RSP),
    .run(r_state == ST_WAIT_RSP),
    .expired(w_expired)
  );
  // Mark completions produced by the watchdog; a real response in the same cycle wins
  always_ff @(posedge clk) begin
    r_rsp_timeout <= reset ? 1'b0 : w_expired && !w_match;
  end
  assign rsp_timeout = r_rsp_timeout;
`else
  assign w_expired = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    r_state <= reset ? ST_IDLE : w_next;
  end

  // Next state, handshake and the one-cycle MMIO request
  always_comb begin
    w_next = r_state;
    if (r_state == ST_IDLE && cmd_valid) w_next = ST_ISSUE;
    else if (r_state == ST_ISSUE) w_next = r_is_wr ? ST_IDLE : ST_WAIT_RSP;
    else if (r_state == ST_WAIT_RSP && (w_match || w_expired)) w_next = ST_IDLE;
    cmd_ready = r_state == ST_IDLE;
    busy = r_state != ST_IDLE;
    c0Rx = '0;
    c0Rx.hdr.address = csr_init_addr(r_idx);
    c0Rx.hdr.length = CSR_INIT_LEN_64;
    c0Rx.hdr.tid = t_csr_init_tid'(r_tid);
    c0Rx.data = 512'(r_wdata);
    c0Rx.mmioRdValid = r_state == ST_ISSUE && !r_is_wr;
    c0Rx.mmioWrValid = r_state == ST_ISSUE && r_is_wr;
  end

  // Command capture, tid bookkeeping and completion outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_wr <= 1'b0;
      r_idx <= '0;
      r_wdata <= '0;
      r_tid <= '0;
      r_out_tid <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        r_is_wr <= cmd_is_wr;
        r_idx <= cmd_idx;
        r_wdata <= cmd_wdata;
      end
      if (r_state == ST_ISSUE) begin
        r_out_tid <= r_tid;
        r_tid <= r_tid + TID_WIDTH'(1);
      end
      r_rsp_valid <= w_match || w_expired;
      if (w_match) r_rsp_data <= c2Tx.data;
      else if (w_expired) r_rsp_data <= '1;
    end
  end
endmodule

// File: tb/tb_csr_mmio_initiator.sv
// tb_csr_mmio_initiator: scoreboard bench for csr_mmio_initiator (request and response queues checked by a monitor)
module tb_csr_mmio_initiator;
  import csr_mmio_initiator_pkg::*;
  localparam int TO = 1024;
  localparam logic [127:0] AFU_ID = 128'hC000C966_0D82_4272_9AEF_FE5F84570612;
  typedef struct packed {
    logic wr;
    logic [15:0] addr;
    logic [8:0] tid;
    logic [63:0] data;
  } t_req;

  logic clk, reset, cmd_valid, cmd_ready, cmd_is_wr, rsp_valid, rsp_timeout, busy;
  t_csr_init_idx cmd_idx;
  logic [63:0] cmd_wdata, rsp_data;
  t_if_cci_c0_Rx c0Rx;
  t_if_cci_c2_Tx c2Tx;

  int n_checks = 0, n_pass = 0, wr40 = 0, n_req = 0, exp_tid = 0;
  logic [8:0] last_tid = '0;
  t_req req_q[$];
  logic [64:0] rsp_q[$];

  csr_mmio_initiator #(.TIMEOUT_CYCLES(TO), .TID_WIDTH(9)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_wr(cmd_is_wr), .cmd_idx(cmd_idx), .cmd_wdata(cmd_wdata),
    .c0Rx(c0Rx), .c2Tx(c2Tx), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input logic wr, input logic [14:0] idx, input logic [63:0] wd);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_before_send", 64'(cmd_ready), 64'(1));
    req_q.push_back('{wr: wr, addr: {idx, 1'b0}, tid: 9'(exp_tid), data: wd});
    exp_tid = (exp_tid + 1) % 512;
    cmd_valid = 1'b1;
    cmd_is_wr = wr;
    cmd_idx = idx;
    cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = '0;
  endtask

  task automatic respond(input logic [8:0] tid, input logic [63:0] d, input logic done);
    if (done) rsp_q.push_back({1'b0, d});
    c2Tx.mmioRdValid = 1'b1;
    c2Tx.hdr.tid = tid;
    c2Tx.data = d;
    @(negedge clk);
    c2Tx = '0;
  endtask

  task automatic rd(input logic [14:0] idx, input logic [63:0] d, input int lat);
    send(1'b0, idx, 64'h0);
    repeat (lat) @(negedge clk);
    respond(9'(exp_tid - 1), d, 1'b1);
    chk("rd_idle_after_rsp", 64'({busy, cmd_ready}), 64'(2'b01));
  endtask

  initial begin : monitor
    t_req e;
    logic [64:0] r;
    forever begin
      @(negedge clk);
      if (c0Rx.mmioRdValid || c0Rx.mmioWrValid) begin
        n_req++;
        last_tid = c0Rx.hdr.tid;
        if (c0Rx.mmioWrValid && c0Rx.hdr.address == 16'h0040) wr40++;
        if (req_q.size() == 0) chk("unexpected_req", 64'(c0Rx.mmioRdValid | c0Rx.mmioWrValid), 64'(0));
        else begin
          e = req_q.pop_front();
          chk("req_kind", 64'({c0Rx.mmioWrValid, c0Rx.mmioRdValid}), 64'({e.wr, !e.wr}));
          chk("req_addr", 64'(c0Rx.hdr.address), 64'(e.addr));
          chk("req_tid", 64'(c0Rx.hdr.tid), 64'(e.tid));
          chk("req_len", 64'(c0Rx.hdr.length), 64'(2'b01));
          chk("req_data", c0Rx.data[63:0], e.data);
          chk("req_data_hi", 64'(|c0Rx.data[511:64]), 64'(0));
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
        else begin
          r = rsp_q.pop_front();
          chk("rsp_data", rsp_data, r[63:0]);
          chk("rsp_timeout", 64'(rsp_timeout), 64'(r[64]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d/%0d checks passed before stall", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : stim
    int w0, t, r0;
    logic [8:0] late;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_is_wr = 1'b0;
    cmd_idx = '0;
    cmd_wdata = '0;
    c2Tx = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_timeout}), 64'(0));
    chk("rst_rsp_data", rsp_data, 64'(0));
    chk("rst_c0_valid", 64'({c0Rx.mmioRdValid, c0Rx.mmioWrValid}), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready), 64'(1));
    rd(15'd1, AFU_ID[63:0], 3);
    w0 = wr40;
    send(1'b1, 15'd32, 64'hDEADBEEF);
    chk("wr_ready_n1", 64'({cmd_ready, busy}), 64'(2'b01));
    @(negedge clk);
    chk("wr_ready_n2", 64'({cmd_ready, busy}), 64'(2'b10));
    repeat (4) begin
      chk("wr_no_rsp", 64'(rsp_valid), 64'(0));
      @(negedge clk);
    end
    chk("wr_pulse_once", 64'(wr40 - w0), 64'(1));
    respond(9'd2, 64'hBAD0, 1'b0);
    chk("idle_stray_rsp", 64'({rsp_valid, busy}), 64'(0));
    send(1'b1, 15'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    send(1'b1, 15'd6, 64'h0123_4567_89AB_CDEF);
    send(1'b1, 15'd7, 64'h0);
    send(1'b0, 15'd9, 64'h0);
    @(negedge clk);
    respond(9'd4, 64'hBAD, 1'b0);
    chk("wrong_tid_ignored", 64'({rsp_valid, busy}), 64'(2'b01));
    respond(9'd5, 64'h1234, 1'b1);
    chk("tid5_done_idle", 64'(busy), 64'(0));
    rd(15'h7FFF, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    rd(15'h2AAA, 64'hA5A5_5A5A_C3C3_3C3C, 6);
    send(1'b0, 15'd3, 64'h0);
    late = 9'(exp_tid - 1);
    repeat (3) @(negedge clk);
    chk("wait_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_rsp", 64'({rsp_valid, rsp_timeout}), 64'(0));
    chk("mid_rst_rsp_data", rsp_data, 64'(0));
    chk("mid_rst_c0_valid", 64'({c0Rx.mmioRdValid, c0Rx.mmioWrValid}), 64'(0));
    reset = 1'b0;
    exp_tid = 0;
    @(negedge clk);
    chk("ready_after_mid_rst", 64'(cmd_ready), 64'(1));
    respond(late, 64'hDEAD, 1'b0);
    chk("late_rsp_ignored", 64'({rsp_valid, busy}), 64'(0));
    r0 = n_req;
    for (int i = 0; i < 513; i++) begin
      rd(15'(i), {32'(i), ~32'(i)}, 1);
      if (i == 511) chk("tid_511", 64'(last_tid), 64'(511));
    end
    chk("tid_wrap_513th", 64'(last_tid), 64'(0));
    chk("req_count_513", 64'(n_req - r0), 64'(513));
`ifdef CSR_MMIO_INITIATOR_TIMEOUT_EN
    rsp_q.push_back({1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    send(1'b0, 15'd100, 64'h0);
    t = 0;
    while (!rsp_valid && t < TO + 20) begin
      @(negedge clk);
      t++;
    end
    chk("to_seen", 64'(rsp_valid), 64'(1));
    chk("to_min_wait", 64'(t >= TO), 64'(1));
    @(negedge clk);
    chk("to_idle", 64'(busy), 64'(0));
`else
    send(1'b0, 15'd100, 64'h0);
    t = 0;
    repeat (TO + 50) begin
      @(negedge clk);
      if (rsp_valid || !busy) t++;
    end
    chk("no_to_wait_persists", 64'(t), 64'(0));
    respond(9'(exp_tid - 1), 64'h5555_0000_5555_0000, 1'b1);
    chk("no_to_done_idle", 64'(busy), 64'(0));
`endif
    repeat (3) @(negedge clk);
    chk("req_q_drained", 64'(req_q.size()), 64'(0));
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
